// File: rtl/c2h_crdt_arb.sv
// c2h_crdt_arb: packet-atomic round-robin arbiter in front of the credit-based
// C2H streaming port of the PCIe core.
//
// NUM_REQ requester streams share one 512-bit output. Each output beat spends
// one credit of its channel (4 channels). The downstream side has no ready, so
// a beat is only launched when its channel holds a credit. Once a requester is
// granted, it keeps the port until its tlast beat has gone out.
//
// Optional build macro: C2H_CRDT_ARB_PARITY_CHK_EN adds the per-byte even
// parity checker driving the sticky par_err flag. Without it, par_err is 0.
//
// Handshake: on the requester side a beat transfers on a cycle where both
// req_tvalid[r] and req_tready[r] are high. req_tvalid must not wait for
// req_tready. req_tready is combinational from registered state only. The
// m_* side has no ready: every cycle with m_tvalid=1 is one delivered beat.
module c2h_crdt_arb #(
  parameter int NUM_REQ = 4,
  parameter int CRDT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_tvalid,
  output logic [NUM_REQ-1:0]     req_tready,
  input  logic [NUM_REQ*512-1:0] req_tdata,
  input  logic [NUM_REQ*64-1:0]  req_tparity,
  input  logic [NUM_REQ*64-1:0]  req_tkeep,
  input  logic [NUM_REQ-1:0]     req_tlast,
  input  logic [NUM_REQ*128-1:0] req_tusr,
  input  logic [NUM_REQ*2-1:0]   req_tch,
  output logic [511:0]           m_tdata,
  output logic [63:0]            m_tparity,
  output logic [63:0]            m_tkeep,
  output logic                   m_tlast,
  output logic [127:0]           m_tusr,
  output logic                   m_tvalid,
  output logic [1:0]             m_tch,
  input  logic                   crdt,
  input  logic [1:0]             crdt_ch,
  output logic [4*CRDT_W-1:0]    crdt_cnt,
  output logic                   crdt_ovf,
  output logic                   par_err,
  output logic                   dbg_state
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [GW:0]       NR_W     = (GW+1)'(NUM_REQ);
  localparam logic [GW-1:0]     LAST_REQ = GW'(NUM_REQ - 1);
  localparam logic [CRDT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   gnt, gnt_nxt;
  logic [GW-1:0]   rr_ptr, rr_nxt;
  logic [1:0]      ch, ch_nxt;
  logic [CRDT_W-1:0] cnt [4];
  logic [3:0]      cnt_nz;
  logic [3:0]      crdt_ret;
  logic [3:0]      crdt_use;

  logic [511:0]    lane_data [NUM_REQ];
  logic [63:0]     lane_par  [NUM_REQ];
  logic [63:0]     lane_keep [NUM_REQ];
  logic [127:0]    lane_usr  [NUM_REQ];
  logic [1:0]      lane_tch  [NUM_REQ];

  logic [NUM_REQ-1:0] elig;
  logic            any_elig;
  logic [GW-1:0]   pick;
  logic            accept;

  assign dbg_state = state;

  // Split the flat requester buses into per-lane views.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      lane_data[r] = req_tdata[r*512 +: 512];
      lane_par[r]  = req_tparity[r*64 +: 64];
      lane_keep[r] = req_tkeep[r*64 +: 64];
      lane_usr[r]  = req_tusr[r*128 +: 128];
      lane_tch[r]  = req_tch[r*2 +: 2];
    end
  end

  // Channel credit availability, based on the registered counters only.
  always_comb begin
    cnt_nz = '0;
    for (int c = 0; c < 4; c++) begin
      cnt_nz[c] = (cnt[c] != '0);
    end
  end

  // Flatten the counters for the status port, channel 0 in the LSBs.
  always_comb begin
    crdt_cnt = '0;
    for (int c = 0; c < 4; c++) begin
      crdt_cnt[c*CRDT_W +: CRDT_W] = cnt[c];
    end
  end

  // A requester may be granted only when its packet's channel has a credit.
  always_comb begin
    elig = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      elig[r] = req_tvalid[r] && cnt_nz[lane_tch[r]];
    end
  end

  // Round-robin pick: scan from the highest offset down so the eligible
  // requester closest to rr_ptr (with wrap) is the one left in pick.
  always_comb begin
    logic [GW:0] sum;
    sum      = '0;
    any_elig = 1'b0;
    pick     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (sum >= NR_W) begin
        sum = sum - NR_W;
      end
      if (elig[sum[GW-1:0]]) begin
        any_elig = 1'b1;
        pick     = sum[GW-1:0];
      end
    end
  end

  // Beat transfer: only the granted lane, only while its latched channel has
  // a credit. The latched ch is used even if the requester changes tch.
  assign accept = (state == XFER) && req_tvalid[gnt] && cnt_nz[ch];

  // Ready goes to the granted lane only, and only while a credit is held.
  always_comb begin
    req_tready = '0;
    if (state == XFER) begin
      req_tready[gnt] = cnt_nz[ch];
    end
  end

  // Arbitration FSM next-state: grant in IDLE, hold the grant through XFER
  // until the tlast beat is accepted, then advance the round-robin pointer.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ch_nxt    = ch;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (any_elig) begin
          state_nxt = XFER;
          gnt_nxt   = pick;
          ch_nxt    = lane_tch[pick];
        end
      end
      XFER: begin
        if (accept && req_tlast[gnt]) begin
          state_nxt = IDLE;
          rr_nxt    = (gnt == LAST_REQ) ? '0 : gnt + GW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, grant, latched channel and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      ch     <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      gnt    <= gnt_nxt;
      ch     <= ch_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Per-channel credit events this cycle: a return and a consumed beat.
  always_comb begin
    crdt_ret = '0;
    crdt_use = '0;
    for (int c = 0; c < 4; c++) begin
      crdt_ret[c] = crdt && (crdt_ch == 2'(c));
      crdt_use[c] = accept && (ch == 2'(c));
    end
  end

  // Credit counters: return and consume on one channel cancel out; a return
  // into a saturated counter is dropped and flagged in the sticky crdt_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        cnt[c] <= '0;
      end
      crdt_ovf <= 1'b0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (crdt_ret[c] && !crdt_use[c]) begin
          if (cnt[c] == CNT_MAX) begin
            crdt_ovf <= 1'b1;
          end else begin
            cnt[c] <= cnt[c] + CRDT_W'(1);
          end
        end else if (crdt_use[c] && !crdt_ret[c]) begin
          cnt[c] <= cnt[c] - CRDT_W'(1);
        end
      end
    end
  end

  // Output register: an accepted beat appears on m_* one cycle later.
  // Payload holds when no beat is launched; only m_tvalid qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid  <= 1'b0;
      m_tlast   <= 1'b0;
      m_tch     <= '0;
      m_tdata   <= '0;
      m_tparity <= '0;
      m_tkeep   <= '0;
      m_tusr    <= '0;
    end else begin
      m_tvalid <= accept;
      if (accept) begin
        m_tlast   <= req_tlast[gnt];
        m_tch     <= ch;
        m_tdata   <= lane_data[gnt];
        m_tparity <= lane_par[gnt];
        m_tkeep   <= lane_keep[gnt];
        m_tusr    <= lane_usr[gnt];
      end
    end
  end

`ifdef C2H_CRDT_ARB_PARITY_CHK_EN
  logic [63:0] byte_bad;

  // Even parity per enabled byte: the byte XOR must match its parity bit.
  always_comb begin
    byte_bad = '0;
    for (int b = 0; b < 64; b++) begin
      byte_bad[b] = lane_keep[gnt][b] &&
                    ((^lane_data[gnt][b*8 +: 8]) != lane_par[gnt][b]);
    end
  end

  // Sticky error, registered alongside the beat so it rises with its m_tvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (accept && (|byte_bad)) begin
      par_err <= 1'b1;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_c2h_crdt_arb.sv
// tb_c2h_crdt_arb: self-checking bench for c2h_crdt_arb.
// Per-requester source queues feed the DUT; the expected output beats are
// pushed when stimulus is queued and popped as m_tvalid beats appear.
`timescale 1ns/1ps
module tb_c2h_crdt_arb;

  localparam int NUM_REQ = 4;
  localparam int CRDT_W  = 8;
  localparam int EW      = 115;

`ifdef C2H_CRDT_ARB_PARITY_CHK_EN
  localparam logic PAR_EXP = 1'b1;
`else
  localparam logic PAR_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [15:0] tag;
    logic [1:0]  ch;
    logic        last;
    logic        bub;
    logic [63:0] pflip;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]     req_tvalid;
  logic [NUM_REQ-1:0]     req_tready;
  logic [NUM_REQ*512-1:0] req_tdata;
  logic [NUM_REQ*64-1:0]  req_tparity;
  logic [NUM_REQ*64-1:0]  req_tkeep;
  logic [NUM_REQ-1:0]     req_tlast;
  logic [NUM_REQ*128-1:0] req_tusr;
  logic [NUM_REQ*2-1:0]   req_tch;
  logic [511:0]           m_tdata;
  logic [63:0]            m_tparity;
  logic [63:0]            m_tkeep;
  logic                   m_tlast;
  logic [127:0]           m_tusr;
  logic                   m_tvalid;
  logic [1:0]             m_tch;
  logic                   crdt;
  logic [1:0]             crdt_ch;
  logic [4*CRDT_W-1:0]    crdt_cnt;
  logic                   crdt_ovf;
  logic                   par_err;
  logic                   dbg_state;

  c2h_crdt_arb #(.NUM_REQ(NUM_REQ), .CRDT_W(CRDT_W)) dut (
    .clk(clk), .rst(rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready),
    .req_tdata(req_tdata), .req_tparity(req_tparity), .req_tkeep(req_tkeep),
    .req_tlast(req_tlast), .req_tusr(req_tusr), .req_tch(req_tch),
    .m_tdata(m_tdata), .m_tparity(m_tparity), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tusr(m_tusr), .m_tvalid(m_tvalid), .m_tch(m_tch),
    .crdt(crdt), .crdt_ch(crdt_ch), .crdt_cnt(crdt_cnt),
    .crdt_ovf(crdt_ovf), .par_err(par_err), .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  beat_t           src_q [NUM_REQ][$];
  logic [EW-1:0]   exp_q [$];
  logic [NUM_REQ-1:0] pend;
  beat_t           hd;
  logic [EW-1:0]   mon_e;
  int              err_cnt = 0;
  int              chk_cnt = 0;
  int              n_out   = 0;
  int              cyc     = 0;
  int              beat_cyc [$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] calc_par(input logic [511:0] d);
    logic [63:0] p;
    p = '0;
    for (int b = 0; b < 64; b++) p[b] = ^d[b*8 +: 8];
    return p;
  endfunction

  function automatic logic [7:0] cnt_of(input int c);
    return crdt_cnt[c*8 +: 8];
  endfunction

  function automatic logic srcs_empty();
    logic e;
    e = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) if (src_q[r].size() != 0) e = 1'b0;
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic add_beat(input int r, input logic [31:0] d, input logic [15:0] tag,
                          input logic [1:0] ch, input logic last, input logic [63:0] pflip);
    beat_t b;
    b.d = d; b.tag = tag; b.ch = ch; b.last = last; b.bub = 1'b0; b.pflip = pflip;
    src_q[r].push_back(b);
  endtask

  task automatic add_bub(input int r);
    beat_t b;
    b = '0;
    b.bub = 1'b1;
    src_q[r].push_back(b);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [15:0] tag, input logic [1:0] ch,
                          input logic last, input logic [63:0] pflip);
    logic [511:0] full;
    full = {16{d}};
    exp_q.push_back({ch, last, tag, d, calc_par(full) ^ pflip});
  endtask

  task automatic give_credit(input logic [1:0] c, input int n);
    crdt_ch = c;
    crdt    = 1'b1;
    tick(n);
    crdt    = 1'b0;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    crdt = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) src_q[r].delete();
    tick(2);
    rst  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i;
    i = 0;
    while (!(exp_q.size() == 0 && srcs_empty() && dbg_state == 1'b0) && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  always @(posedge clk) cyc++;

  // Source driver: present each lane's queue head; pop it once accepted.
  initial begin
    pend = '0;
    req_tvalid = '0; req_tdata = '0; req_tparity = '0; req_tkeep = '0;
    req_tlast = '0; req_tusr = '0; req_tch = '0;
    forever begin
      @(negedge clk);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (pend[r] && src_q[r].size() > 0) void'(src_q[r].pop_front());
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if (src_q[r].size() > 0) hd = src_q[r][0];
        else hd = '0;
        req_tvalid[r]            = (src_q[r].size() > 0) && !hd.bub;
        req_tdata[r*512 +: 512]  = {16{hd.d}};
        req_tparity[r*64 +: 64]  = calc_par({16{hd.d}}) ^ hd.pflip;
        req_tkeep[r*64 +: 64]    = '1;
        req_tlast[r]             = hd.last;
        req_tusr[r*128 +: 128]   = {112'b0, hd.tag};
        req_tch[r*2 +: 2]        = hd.ch;
      end
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (src_q[r].size() > 0) hd = src_q[r][0];
        else hd = '0;
        pend[r] = (src_q[r].size() > 0) &&
                  (hd.bub || (req_tvalid[r] && req_tready[r] && !rst));
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (m_tvalid) begin
      n_out++;
      beat_cyc.push_back(cyc);
      check("sb_avail", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("beat", {m_tch, m_tlast, m_tusr[15:0], m_tdata[31:0], m_tparity}, mon_e);
        check("beat_data_hi", m_tdata[511:384], {4{mon_e[95:64]}});
        check("beat_usr_hi", m_tusr[127:16], 112'd0);
        check("beat_keep", m_tkeep, 64'hFFFF_FFFF_FFFF_FFFF);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int got;
    logic seen;
    crdt = 1'b0;
    crdt_ch = '0;
    rst = 1'b1;
    tick(3);

    // Reset state
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tch", m_tch, 0);
    check("rst_m_tdata_lo", m_tdata[127:0], 0);
    check("rst_m_tusr", m_tusr, 0);
    check("rst_m_tkeep", m_tkeep, 0);
    check("rst_m_tparity", m_tparity, 0);
    check("rst_crdt_cnt", crdt_cnt, 0);
    check("rst_crdt_ovf", crdt_ovf, 0);
    check("rst_par_err", par_err, 0);
    check("rst_tready", req_tready, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    tick(1);

    // Credit gating: 3-beat packet on ch1, no credits yet
    for (int i = 0; i < 3; i++) begin
      add_beat(0, 32'hA000_0000 + i, 16'h0100 + 16'(i), 2'd1, i == 2, '0);
      push_exp(32'hA000_0000 + i, 16'h0100 + 16'(i), 2'd1, i == 2, '0);
    end
    tick(5);
    check("gate_no_beat", n_out, 0);
    check("gate_state_idle", dbg_state, 0);
    give_credit(2'd1, 2);
    tick(6);
    check("gate_two_beats", n_out, 2);
    check("gate_cnt1_zero", cnt_of(1), 0);
    check("gate_stall_xfer", dbg_state, 1);
    check("gate_stall_tready", req_tready, 0);
    give_credit(2'd1, 1);
    wait_drain("gate_drain", 20);
    check("gate_three_beats", n_out, 3);
    check("gate_cnt1_end", cnt_of(1), 0);

    // Round-robin: four 1-beat packets on ch0 plus a second from req0
    do_reset();
    beat_cyc.delete();
    add_beat(0, 32'h5A00_2000, 16'h2000, 2'd0, 1'b1, '0);
    add_beat(1, 32'h5A00_2101, 16'h2101, 2'd0, 1'b1, '0);
    add_beat(2, 32'h5A00_2202, 16'h2202, 2'd0, 1'b1, '0);
    add_beat(3, 32'h5A00_2303, 16'h2303, 2'd0, 1'b1, '0);
    add_beat(0, 32'h5A00_2004, 16'h2004, 2'd0, 1'b1, '0);
    push_exp(32'h5A00_2000, 16'h2000, 2'd0, 1'b1, '0);
    push_exp(32'h5A00_2101, 16'h2101, 2'd0, 1'b1, '0);
    push_exp(32'h5A00_2202, 16'h2202, 2'd0, 1'b1, '0);
    push_exp(32'h5A00_2303, 16'h2303, 2'd0, 1'b1, '0);
    push_exp(32'h5A00_2004, 16'h2004, 2'd0, 1'b1, '0);
    give_credit(2'd0, 10);
    wait_drain("rr_drain", 30);
    check("rr_beat_count", beat_cyc.size(), 5);
    for (int i = 1; i < 5; i++) begin
      if (i < beat_cyc.size()) check("rr_beat_spacing", beat_cyc[i] - beat_cyc[i-1], 2);
    end
    check("rr_cnt0", cnt_of(0), 5);

    // Atomicity: 4-beat packet on ch2 with a bubble, tch changes on last beat
    do_reset();
    add_beat(0, 32'hB000_0000, 16'h3000, 2'd2, 1'b0, '0);
    add_beat(0, 32'hB000_0001, 16'h3001, 2'd2, 1'b0, '0);
    add_bub(0);
    add_beat(0, 32'hB000_0002, 16'h3002, 2'd2, 1'b0, '0);
    add_beat(0, 32'hB000_0003, 16'h3003, 2'd3, 1'b1, '0);
    add_beat(1, 32'hB100_0000, 16'h3100, 2'd2, 1'b1, '0);
    push_exp(32'hB000_0000, 16'h3000, 2'd2, 1'b0, '0);
    push_exp(32'hB000_0001, 16'h3001, 2'd2, 1'b0, '0);
    push_exp(32'hB000_0002, 16'h3002, 2'd2, 1'b0, '0);
    push_exp(32'hB000_0003, 16'h3003, 2'd2, 1'b1, '0);
    push_exp(32'hB100_0000, 16'h3100, 2'd2, 1'b1, '0);
    give_credit(2'd2, 8);
    wait_drain("atom_drain", 30);
    check("atom_cnt2", cnt_of(2), 3);
    check("atom_cnt3", cnt_of(3), 0);

    // Simultaneous return and consume on ch3, then saturation on ch0
    do_reset();
    give_credit(2'd3, 1);
    add_beat(2, 32'hC000_0000, 16'h4200, 2'd3, 1'b1, '0);
    push_exp(32'hC000_0000, 16'h4200, 2'd3, 1'b1, '0);
    tick(1);
    give_credit(2'd3, 1);
    check("simul_accept", m_tvalid, 1);
    check("simul_cnt3", cnt_of(3), 1);
    wait_drain("simul_drain", 10);
    give_credit(2'd0, 255);
    check("sat_cnt0_full", cnt_of(0), 255);
    check("sat_no_ovf", crdt_ovf, 0);
    give_credit(2'd0, 1);
    check("sat_cnt0_hold", cnt_of(0), 255);
    check("sat_ovf", crdt_ovf, 1);
    tick(1);
    check("sat_ovf_sticky", crdt_ovf, 1);

    // Reset mid-packet after beat 2 of 5
    do_reset();
    give_credit(2'd1, 5);
    for (int i = 0; i < 5; i++) add_beat(0, 32'hD000_0000 + i, 16'h5000 + 16'(i), 2'd1, i == 4, '0);
    push_exp(32'hD000_0000, 16'h5000, 2'd1, 1'b0, '0);
    push_exp(32'hD000_0001, 16'h5001, 2'd1, 1'b0, '0);
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      tick(1);
      if (m_tvalid) got++;
    end
    check("mid_two_beats", got, 2);
    rst = 1'b1;
    tick(1);
    src_q[0].delete();
    check("mid_rst_tvalid", m_tvalid, 0);
    check("mid_rst_cnt", crdt_cnt, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_ovf", crdt_ovf, 0);
    check("mid_rst_tready", req_tready, 0);
    rst = 1'b0;
    tick(1);
    give_credit(2'd1, 2);
    add_beat(1, 32'hD100_0000, 16'h5100, 2'd1, 1'b1, '0);
    push_exp(32'hD100_0000, 16'h5100, 2'd1, 1'b1, '0);
    wait_drain("post_rst_drain", 20);
    check("post_rst_cnt1", cnt_of(1), 1);

    // Parity: byte 5 parity flipped, data passes unchanged
    do_reset();
    give_credit(2'd0, 2);
    add_beat(0, 32'hE1E2_E3E4, 16'h6000, 2'd0, 1'b1, 64'h20);
    push_exp(32'hE1E2_E3E4, 16'h6000, 2'd0, 1'b1, 64'h20);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      if (m_tvalid) begin
        seen = 1'b1;
        check("par_err_on_beat", par_err, PAR_EXP);
      end else begin
        check("par_err_before", par_err, 0);
      end
    end
    check("par_beat_seen", seen, 1);
    wait_drain("par_drain", 10);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/c2h_crdt_arb.md
Name: c2h_crdt_arb

Overview:
- Packet-atomic round-robin arbiter feeding the credit-based C2H streaming interface toward the PCIe core.
- Shares that interface between NUM_REQ requesters and tracks one credit counter per channel (4 channels, selected by tch/crdt_ch).
- A beat is issued only when its channel holds a credit; the slave has no ready, so every issued beat is guaranteed accepted.
- Sits between the C2H engine's per-queue stream sources and the PCIe core's C2H port.

Parameters:
- NUM_REQ, 4, number of requester streams (2..8).
- CRDT_W, 8, width of each per-channel credit counter.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- req_tvalid  in  NUM_REQ  per-requester beat valid
- req_tready  out  NUM_REQ  per-requester beat accept (combinational)
- req_tdata  in  NUM_REQ*512  per-requester data
- req_tparity  in  NUM_REQ*64  per-byte even parity
- req_tkeep  in  NUM_REQ*64  byte enables
- req_tlast  in  NUM_REQ  end of packet
- req_tusr  in  NUM_REQ*128  sideband user bits
- req_tch  in  NUM_REQ*2  target channel, stable for a whole packet
- m_tdata  out  512  registered output data
- m_tparity  out  64  registered output parity
- m_tkeep  out  64  registered output byte enables
- m_tlast  out  1  registered end of packet
- m_tusr  out  128  registered sideband
- m_tvalid  out  1  registered beat valid; each assertion consumes one credit
- m_tch  out  2  registered channel
- crdt  in  1  one credit returned this cycle
- crdt_ch  in  2  channel of the returned credit
- crdt_cnt  out  4*CRDT_W  live credit counters, channel 0 in the LSBs
- crdt_ovf  out  1  sticky: a credit return hit a saturated counter
- par_err  out  1  sticky parity error (optional feature only)

Behaviour:
- Reset (synchronous, rst=1):
  - m_tvalid=0, m_tlast=0, m_tch=0, m_tdata/tparity/tkeep/tusr=0.
  - All crdt_cnt=0, crdt_ovf=0, par_err=0, req_tready=0.
  - FSM=IDLE, rr_ptr=0.
  - Reset mid-packet drops the packet. There is no recovery; the slave re-issues initial credits after reset.
- Credits:
  - One credit equals one 512-bit beat.
  - Per cycle: cnt[c] <= cnt[c] + (crdt && crdt_ch==c) - (beat accepted on channel c).
  - Return and consume on the same channel in the same cycle leaves the count unchanged.
  - Return at cnt = 2^CRDT_W-1 with no consume: counter holds and crdt_ovf is set.
  - Eligibility uses the registered count only; a same-cycle return is not counted.
- FSM IDLE:
  - Requester r is eligible when req_tvalid[r]=1 and cnt[req_tch[r]]>0.
  - Grant the first eligible requester scanning from rr_ptr upward, with wrap.
  - Latch gnt=r and ch=req_tch[r]; go to XFER. No beat is accepted in IDLE.
  - req_tready is all 0 in IDLE.
- FSM XFER:
  - req_tready[gnt] = (cnt[ch]>0); all other tready bits are 0.
  - Beat accepted when req_tvalid[gnt] && req_tready[gnt].
  - Accepted beat appears on m_* exactly 1 cycle later with m_tvalid=1 and m_tch=ch. Otherwise m_tvalid=0 the next cycle; m_* data is don't-care when m_tvalid=0.
  - Accepted beat with tlast=1: go to IDLE, rr_ptr <= gnt+1 mod NUM_REQ.
  - Credit starvation mid-packet stalls in XFER. The grant is held, so the packet is never interleaved.
  - Bubble (req_tvalid[gnt]=0): stay in XFER.
- Throughput: 1 beat/cycle inside a packet; 1 idle cycle between packets.
- Single-beat packet (tlast on first beat) is legal and takes 2 cycles including arbitration.
- A tch change within a packet is ignored; the latched ch is used.

Optional Feature:
- Macro: C2H_CRDT_ARB_PARITY_CHK_EN
- Enabled:
  - For each accepted beat, check every byte with tkeep=1: the byte's XOR must equal its tparity bit.
  - Any mismatch sets sticky par_err on the cycle m_tvalid presents that beat.
  - Data still passes through unmodified.
- Disabled: no checker logic; par_err is tied 0.

Test Plan:
- Credit gating: reset; req0 valid, 3-beat packet on ch1; no credits -> m_tvalid stays 0. Return 2 credits on ch1 -> 2 beats out, stall, cnt[1]=0. Return 1 more -> tlast beat out; cnt[1]=0 at end.
- Round-robin: cnt[0]=10; req0..req3 each hold a 1-beat packet on ch0 continuously -> m_tusr order req0,req1,req2,req3,req0; beat every 2 cycles.
- Atomicity: req0 sends a 4-beat packet on ch2, req1 is valid throughout -> all 4 req0 beats are contiguous before any req1 beat, even with a 1-cycle tvalid bubble at beat 2.
- Simultaneous events: cnt[3]=1; credit return on ch3 in the same cycle a ch3 beat is accepted -> cnt[3] stays 1. With CRDT_W=8 and cnt=255, a return -> cnt=255, crdt_ovf=1.
- Reset mid-packet: rst=1 after beat 2 of 5 -> next cycle m_tvalid=0, all cnt=0, FSM=IDLE. Post-reset, req1 is granted first when eligible (rr_ptr=0, req0 idle).
- Parity (macro on): byte 5 parity flipped, tkeep all ones -> par_err=1 in the same cycle that beat's m_tvalid=1; data is unchanged.
